acc_cpu_core: RTL and testbench

- Parametrised accumulator CPU core. Next-generation replacement for the fixed 4-bit datapath built from discrete ALU/PC/RAM/ROM blocks.
- A fetch/decode/execute state machine runs programs from an external synchronous program ROM. It uses an internal data RAM, an accumulator, and carry/zero flags.
- It adds the following over the 4-bit datapath:
  - configurable widths
  - reset
  - start control
  - conditional branches on carry and zero
  - an explicit halt state

---
 rtl/acc_cpu_core.sv | 256 +++++++++++++++++++++++++
 tb/tb_acc_cpu_core.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_cpu_core.sv
`default_nettype none
// ============================================================================
//  Module      : acc_cpu_core
//  Description : Parametrised accumulator CPU core. A three-cycle
//                FETCH/DECODE/EXEC sequencer runs a program held in an
//                external synchronous ROM. The core has an internal data
//                RAM, an accumulator and carry/zero flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_cpu_core #(
  parameter int DATA_W = 4,
  parameter int PC_W   = 4,
  parameter int RAM_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [PC_W-1:0]   prog_addr,
  input  logic [DATA_W+3:0] prog_data,
  output logic [DATA_W-1:0] acc,
  output logic              flag_c,
  output logic              flag_z,
  output logic              busy,
  output logic              halted
);

  // --------------------------------------------------------------------------
  // Sequencer states
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_FETCH  = 3'd1;
  localparam logic [2:0] c_DECODE = 3'd2;
  localparam logic [2:0] c_EXEC   = 3'd3;
  localparam logic [2:0] c_HALT   = 3'd4;

  // --------------------------------------------------------------------------
  // Opcodes
  // --------------------------------------------------------------------------
  localparam logic [3:0] c_OP_NOP  = 4'h0;
  localparam logic [3:0] c_OP_LDI  = 4'h1;
  localparam logic [3:0] c_OP_LDM  = 4'h2;
  localparam logic [3:0] c_OP_STM  = 4'h3;
  localparam logic [3:0] c_OP_ADDI = 4'h4;
  localparam logic [3:0] c_OP_ADDM = 4'h5;
  localparam logic [3:0] c_OP_SUBI = 4'h6;
  localparam logic [3:0] c_OP_SUBM = 4'h7;
  localparam logic [3:0] c_OP_ANDM = 4'h8;
  localparam logic [3:0] c_OP_ORM  = 4'h9;
  localparam logic [3:0] c_OP_XORM = 4'hA;
  localparam logic [3:0] c_OP_NOT  = 4'hB;
  localparam logic [3:0] c_OP_JMP  = 4'hC;
  localparam logic [3:0] c_OP_JZ   = 4'hD;
  localparam logic [3:0] c_OP_JC   = 4'hE;
  localparam logic [3:0] c_OP_HLT  = 4'hF;

  localparam int              c_RAM_DEPTH = 2 ** RAM_AW;
  localparam logic [PC_W-1:0] c_PC_ONE    = 1;

  // --------------------------------------------------------------------------
  // Architectural and pipeline registers
  // --------------------------------------------------------------------------
  logic [2:0]        r_state;
  logic [PC_W-1:0]   r_pc;
  logic [DATA_W+3:0] r_ir;
  logic [DATA_W-1:0] r_acc;
  logic              r_flagC;
  logic              r_flagZ;
  logic [DATA_W-1:0] r_ramRd;
  logic [DATA_W-1:0] r_ram [c_RAM_DEPTH];

  // --------------------------------------------------------------------------
  // Instruction fields and execute-stage controls
  // --------------------------------------------------------------------------
  logic [3:0]        w_opcode;
  logic [DATA_W-1:0] w_operand;
  logic [RAM_AW-1:0] w_ramWrAddr;
  logic [RAM_AW-1:0] w_ramRdAddr;
  logic [PC_W-1:0]   w_jmpTarget;
  logic              w_inExec;

  logic [DATA_W-1:0] w_aluSrc;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;

  logic              w_accWe;
  logic [DATA_W-1:0] w_accNext;
  logic              w_cWe;
  logic              w_cNext;
  logic              w_jump;
  logic              w_halt;
  logic              w_ramWe;

  assign w_opcode    = r_ir[DATA_W+3:DATA_W];
  assign w_operand   = r_ir[DATA_W-1:0];
  // High operand bits beyond the RAM/PC width are simply dropped.
  assign w_ramWrAddr = w_operand[RAM_AW-1:0];
  assign w_ramRdAddr = prog_data[RAM_AW-1:0];
  assign w_jmpTarget = w_operand[PC_W-1:0];
  assign w_inExec    = (r_state == c_EXEC);

  // Odd arithmetic opcodes (ADDM/SUBM) take the RAM word, even ones the immediate.
  assign w_aluSrc = w_opcode[0] ? r_ramRd : w_operand;

  // One extra bit on the left holds carry-out (add) or borrow (subtract).
  assign w_sum  = {1'b0, r_acc} + {1'b0, w_aluSrc};
  assign w_diff = {1'b0, r_acc} - {1'b0, w_aluSrc};

  // Decode the latched opcode into accumulator, carry, branch and halt actions.
  always_comb begin
    w_accWe   = 1'b0;
    w_accNext = r_acc;
    w_cWe     = 1'b0;
    w_cNext   = r_flagC;
    w_jump    = 1'b0;
    w_halt    = 1'b0;
    case (w_opcode)
      c_OP_NOP: begin
      end
      c_OP_LDI: begin
        w_accWe   = 1'b1;
        w_accNext = w_operand;
      end
      c_OP_LDM: begin
        w_accWe   = 1'b1;
        w_accNext = r_ramRd;
      end
      c_OP_STM: begin
      end
      c_OP_ADDI, c_OP_ADDM: begin
        w_accWe   = 1'b1;
        w_accNext = w_sum[DATA_W-1:0];
        w_cWe     = 1'b1;
        w_cNext   = w_sum[DATA_W];
      end
      c_OP_SUBI, c_OP_SUBM: begin
        // Carry set means no borrow, i.e. acc >= operand before the op.
        w_accWe   = 1'b1;
        w_accNext = w_diff[DATA_W-1:0];
        w_cWe     = 1'b1;
        w_cNext   = ~w_diff[DATA_W];
      end
      c_OP_ANDM: begin
        w_accWe   = 1'b1;
        w_accNext = r_acc & r_ramRd;
        w_cWe     = 1'b1;
        w_cNext   = 1'b0;
      end
      c_OP_ORM: begin
        w_accWe   = 1'b1;
        w_accNext = r_acc | r_ramRd;
        w_cWe     = 1'b1;
        w_cNext   = 1'b0;
      end
      c_OP_XORM: begin
        w_accWe   = 1'b1;
        w_accNext = r_acc ^ r_ramRd;
        w_cWe     = 1'b1;
        w_cNext   = 1'b0;
      end
      c_OP_NOT: begin
        w_accWe   = 1'b1;
        w_accNext = ~r_acc;
        w_cWe     = 1'b1;
        w_cNext   = 1'b0;
      end
      c_OP_JMP: begin
        w_jump = 1'b1;
      end
      c_OP_JZ: begin
        w_jump = r_flagZ;
      end
      c_OP_JC: begin
        w_jump = r_flagC;
      end
      c_OP_HLT: begin
        w_halt = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // A store that lands on the same edge as reset is dropped.
  assign w_ramWe = w_inExec && (w_opcode == c_OP_STM) && !rst;

  // Sequencer, program counter, instruction register, accumulator and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_acc   <= '0;
      r_flagC <= 1'b0;
      r_flagZ <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (run) begin
            r_state <= c_FETCH;
          end
        end
        c_FETCH: begin
          // prog_addr already equals pc; the ROM word arrives during DECODE.
          r_state <= c_DECODE;
        end
        c_DECODE: begin
          r_ir    <= prog_data;
          r_state <= c_EXEC;
        end
        c_EXEC: begin
          if (w_halt) begin
            r_state <= c_HALT;
          end else begin
            r_state <= c_FETCH;
            r_pc    <= w_jump ? w_jmpTarget : (r_pc + c_PC_ONE);
          end
          if (w_accWe) begin
            r_acc   <= w_accNext;
            r_flagZ <= (w_accNext == '0);
          end
          if (w_cWe) begin
            r_flagC <= w_cNext;
          end
        end
        c_HALT: begin
          // Terminal until reset.
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // Data RAM: write from EXEC, registered read addressed by the ROM word in DECODE.
  always_ff @(posedge clk) begin
    if (w_ramWe) begin
      r_ram[w_ramWrAddr] <= r_acc;
    end
    if (r_state == c_DECODE) begin
      r_ramRd <= r_ram[w_ramRdAddr];
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign prog_addr = r_pc;
  assign acc       = r_acc;
  assign flag_c    = r_flagC;
  assign flag_z    = r_flagZ;
  assign busy      = (r_state == c_FETCH) || (r_state == c_DECODE) || w_inExec;
  assign halted    = (r_state == c_HALT);

endmodule
`default_nettype wire

// File: tb/tb_acc_cpu_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acc_cpu_core
//  Description : Scoreboard bench for acc_cpu_core. An instruction-level
//                model predicts the architectural state after every
//                instruction; a monitor compares it when the result appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_cpu_core;

  localparam int DW = 4;
  localparam int PW = 4;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic [PW-1:0] prog_addr;
  logic [DW+3:0] prog_data;
  logic [DW-1:0] acc;
  logic          flag_c;
  logic          flag_z;
  logic          busy;
  logic          halted;

  always #5 clk = ~clk;

  acc_cpu_core #(
    .DATA_W(DW),
    .PC_W  (PW),
    .RAM_AW(AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .acc      (acc),
    .flag_c   (flag_c),
    .flag_z   (flag_z),
    .busy     (busy),
    .halted   (halted)
  );

  // Synchronous program ROM: word appears one cycle after the address.
  logic [7:0] rom [16];
  always @(posedge clk) prog_data <= rom[prog_addr];

  typedef struct {
    int pc;
    int acc;
    int c;
    int z;
    int h;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  int mPc, mAcc, mC, mZ;
  int mRam [16];

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Execute one instruction at the ISA level.
  task automatic model_step(output bit hlt);
    logic [7:0] w;
    int op, imm, m, res, nxt;
    bit wr;
    w   = rom[mPc];
    op  = int'(w[7:4]);
    imm = int'(w[3:0]);
    m   = mRam[imm];
    nxt = (mPc + 1) % 16;
    wr  = 0;
    res = 0;
    hlt = 0;
    case (op)
      1:  begin res = imm; wr = 1; end
      2:  begin res = m; wr = 1; end
      3:  mRam[imm] = mAcc;
      4:  begin res = mAcc + imm; mC = (res > 15) ? 1 : 0; res = res % 16; wr = 1; end
      5:  begin res = mAcc + m;   mC = (res > 15) ? 1 : 0; res = res % 16; wr = 1; end
      6:  begin mC = (mAcc >= imm) ? 1 : 0; res = (mAcc - imm + 16) % 16; wr = 1; end
      7:  begin mC = (mAcc >= m)   ? 1 : 0; res = (mAcc - m + 16) % 16;   wr = 1; end
      8:  begin res = mAcc & m; mC = 0; wr = 1; end
      9:  begin res = mAcc | m; mC = 0; wr = 1; end
      10: begin res = mAcc ^ m; mC = 0; wr = 1; end
      11: begin res = 15 - mAcc; mC = 0; wr = 1; end
      12: nxt = imm;
      13: if (mZ == 1) nxt = imm;
      14: if (mC == 1) nxt = imm;
      15: begin nxt = mPc; hlt = 1; end
      default: ;
    endcase
    if (wr) begin
      mAcc = res;
      mZ   = (res == 0) ? 1 : 0;
    end
    mPc = nxt;
  endtask

  task automatic push_state(int h);
    exp_t e;
    e.pc = mPc; e.acc = mAcc; e.c = mC; e.z = mZ; e.h = h;
    q.push_back(e);
  endtask

  // Start the core and let the monitor consume up to n instruction results.
  task automatic go(string tag, int n);
    bit h;
    int budget;
    h = 0;
    for (int i = 0; i < n && !h; i++) begin
      model_step(h);
      push_state(h ? 1 : 0);
    end
    if (h) repeat (2) push_state(1);
    @(negedge clk);
    run = 1'b1;
    budget = 3 * (n + 4) + 10;
    while (q.size() != 0 && budget > 0) begin
      @(negedge clk);
      #1;
      run = 1'($urandom_range(0, 1));
      budget--;
    end
    chk({tag, "_pending"}, q.size(), 0);
    q.delete();
  endtask

  task automatic do_reset(string tag, int idleCycles);
    run = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mPc = 0; mAcc = 0; mC = 0; mZ = 0;
    repeat (idleCycles) begin
      @(negedge clk);
      chk({tag, "_acc"},    acc, 0);
      chk({tag, "_c"},      flag_c, 0);
      chk({tag, "_z"},      flag_z, 0);
      chk({tag, "_busy"},   busy, 0);
      chk({tag, "_halted"}, halted, 0);
      chk({tag, "_pc"},     prog_addr, 0);
    end
  endtask

  task automatic fill_rom(logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  // Monitor: a result becomes visible the cycle after each EXEC.
  int   cyc = 0;
  exp_t monE;
  always @(negedge clk) begin
    if (rst || (!busy && !halted)) begin
      cyc = 0;
    end else begin
      cyc++;
      if (cyc >= 4 && ((cyc - 1) % 3) == 0 && q.size() > 0) begin
        monE = q.pop_front();
        chk("mon_pc",     prog_addr, monE.pc);
        chk("mon_acc",    acc,       monE.acc);
        chk("mon_c",      flag_c,    monE.c);
        chk("mon_z",      flag_z,    monE.z);
        chk("mon_halted", halted,    monE.h);
        chk("mon_busy",   busy,      (monE.h == 0) ? 1 : 0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int base;
    logic [3:0] v;
    fill_rom(8'h00);
    for (int i = 0; i < 16; i++) mRam[i] = 0;

    // Reset and idle with run low
    do_reset("idle", 10);

    // Initialise every RAM word (address 2 gets 0)
    for (int k = 0; k < 3; k++) begin
      fill_rom(8'hF0);
      base = k * 7;
      for (int i = 0; i < 7 && base + i < 16; i++) begin
        v = 4'($urandom_range(0, 15));
        if (base + i == 2) v = 4'd0;
        rom[2 * i]     = {4'h1, v};
        rom[2 * i + 1] = {4'h3, 4'(base + i)};
      end
      go("init", 16);
      do_reset("rst_init", 1);
    end

    // Add with carry
    fill_rom(8'hF0);
    rom[0] = 8'h19; rom[1] = 8'h48; rom[2] = 8'hF0;
    go("add", 5);
    chk("add_acc", acc, 1);
    chk("add_c", flag_c, 1);
    chk("add_z", flag_z, 0);
    chk("add_halted", halted, 1);
    do_reset("rst_add", 1);

    // Store then subtract from memory (borrow)
    fill_rom(8'hF0);
    rom[0] = 8'h15; rom[1] = 8'h33; rom[2] = 8'h12; rom[3] = 8'h73; rom[4] = 8'hF0;
    go("subm", 8);
    chk("subm_acc", acc, 13);
    chk("subm_c", flag_c, 0);
    do_reset("rst_subm", 1);

    // Load back what was stored
    rom[4] = 8'h23; rom[5] = 8'hF0;
    go("ldm", 8);
    chk("ldm_acc", acc, 5);
    chk("ldm_z", flag_z, 0);
    do_reset("rst_ldm", 1);

    // Countdown loop with conditional branch
    fill_rom(8'hF0);
    rom[0] = 8'h13; rom[1] = 8'h61; rom[2] = 8'hD4; rom[3] = 8'hC1; rom[4] = 8'hF0;
    go("loop", 14);
    chk("loop_acc", acc, 0);
    chk("loop_z", flag_z, 1);
    chk("loop_c", flag_c, 1);
    chk("loop_pc", prog_addr, 4);
    chk("loop_halted", halted, 1);
    do_reset("rst_loop", 1);

    // Program counter wrap
    fill_rom(8'h00);
    rom[0] = 8'h17;
    go("wrap", 20);
    chk("wrap_acc", acc, 7);
    do_reset("rst_wrap", 1);

    // Reset during EXEC of a store: store must be dropped
    fill_rom(8'hF0);
    rom[0] = 8'h16; rom[1] = 8'h32;
    go("midrst", 1);
    repeat (2) @(negedge clk);
    do_reset("midrst_idle", 2);
    fill_rom(8'hF0);
    rom[0] = 8'h22;
    go("midrst_ld", 3);
    chk("midrst_acc", acc, 0);
    chk("midrst_z", flag_z, 1);
    do_reset("rst_midrst", 1);

    // Random programs
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
      go("rand", 40);
      do_reset("rst_rand", 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
